// File: rtl/matrix_bank_loader.sv
// Matrix load receiver: tags controller reads, captures returned ROM/RAM words into 8x8 weight/input banks.
// Latency: word written LATENCY clks after its request; row outputs are combinational from row_sel.
// Backpressure: none, accepts one request per clk; BANK_LOADER_ERR_EN adds a written bitmap and overwrite_err.
module matrix_bank_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int BANKS      = 8,
    parameter int LANES      = 8,
    parameter int LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          read_en,
    input  logic [3:0]                    bank_select_line,
    input  logic [2:0]                    select_line,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    input  logic [DATA_WIDTH-1:0]         ram_data,
    input  logic                          clear,
    input  logic [2:0]                    row_sel,
    output logic [LANES*DATA_WIDTH-1:0]   w_row,
    output logic [LANES*DATA_WIDTH-1:0]   x_row,
    output logic [6:0]                    write_count,
    output logic                          loaded,
    output logic                          overwrite_err
);

    localparam int BW            = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int LW            = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TOTAL         = BANKS * LANES;
    localparam logic [6:0] TOTAL_CNT = 7'(TOTAL);

    typedef struct packed {
        logic       vld;
        logic [3:0] bank;
        logic [2:0] lane;
    } tag_t;

    tag_t tag_pipe [LATENCY];
    tag_t tag_out;

    logic [DATA_WIDTH-1:0] wbank [BANKS][LANES];
    logic [DATA_WIDTH-1:0] xbank [BANKS][LANES];

    logic          in_range;
    logic          room;
    logic          wr_en;
    logic          dup;
    logic [BW-1:0] wr_bank;
    logic [LW-1:0] wr_lane;
    logic [6:0]    base_cnt;
    logic [6:0]    next_cnt;
    logic          row_ok;
    logic [BW-1:0] rd_row;

    // Tag pipeline mirrors the memory read latency and shifts regardless of enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].vld  <= read_en & enable;
            tag_pipe[0].bank <= bank_select_line;
            tag_pipe[0].lane <= select_line;
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out  = tag_pipe[LATENCY-1];
    assign in_range = {1'b0, tag_out.bank} < 5'(BANKS);
    // A clear restarts the pass, so a coincident write is admitted even if the old pass was full.
    assign room     = clear | (write_count < TOTAL_CNT);
    assign wr_en    = tag_out.vld & in_range & room;
    assign wr_bank  = tag_out.bank[BW-1:0];
    assign wr_lane  = tag_out.lane[LW-1:0];

`ifdef BANK_LOADER_ERR_EN
    localparam int SW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic [TOTAL-1:0] written;
    logic [SW-1:0]    slot;

    assign slot = SW'(wr_bank * LANES + wr_lane);
    assign dup  = ~clear & written[slot];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written       <= '0;
            overwrite_err <= 1'b0;
        end else begin
            if (clear) begin
                written <= '0;
            end
            if (wr_en) begin
                written[slot] <= 1'b1;
            end
            overwrite_err <= clear ? 1'b0 : (overwrite_err | (wr_en & dup));
        end
    end
`else
    assign dup           = 1'b0;
    assign overwrite_err = 1'b0;
`endif

    assign base_cnt = clear ? 7'd0 : write_count;
    assign next_cnt = base_cnt + 7'(wr_en & ~dup);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_count <= '0;
            loaded      <= 1'b0;
        end else begin
            write_count <= next_cnt;
            loaded      <= (next_cnt == TOTAL_CNT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    wbank[b][l] <= '0;
                    xbank[b][l] <= '0;
                end
            end
        end else if (wr_en) begin
            wbank[wr_bank][wr_lane] <= rom_data;
            xbank[wr_bank][wr_lane] <= ram_data;
        end
    end

    assign row_ok = {1'b0, row_sel} < 4'(BANKS);
    assign rd_row = row_sel[BW-1:0];

    always_comb begin
        w_row = '0;
        x_row = '0;
        if (row_ok) begin
            for (int l = 0; l < LANES; l++) begin
                w_row[l*DATA_WIDTH +: DATA_WIDTH] = wbank[rd_row][l];
                x_row[l*DATA_WIDTH +: DATA_WIDTH] = xbank[rd_row][l];
            end
        end
    end

endmodule

// File: tb/tb_matrix_bank_loader.sv
// Directed bench for matrix_bank_loader with a 2-cycle ROM/RAM model; honours BANK_LOADER_ERR_EN.
module tb_matrix_bank_loader;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         read_en;
    logic [3:0]   bank_select_line;
    logic [2:0]   select_line;
    logic [31:0]  rom_data;
    logic [31:0]  ram_data;
    logic         clear;
    logic [2:0]   row_sel;
    logic [255:0] w_row;
    logic [255:0] x_row;
    logic [6:0]   write_count;
    logic         loaded;
    logic         overwrite_err;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model: address (and a data offset) registered twice, data valid 2 clks after the request.
    int cur_ofs = 0;
    int p1_b = 0, p1_l = 0, p1_o = 0;
    int p2_b = 0, p2_l = 0, p2_o = 0;

    matrix_bank_loader #(
        .DATA_WIDTH(32), .BANKS(8), .LANES(8), .LATENCY(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .read_en(read_en),
        .bank_select_line(bank_select_line), .select_line(select_line),
        .rom_data(rom_data), .ram_data(ram_data), .clear(clear), .row_sel(row_sel),
        .w_row(w_row), .x_row(x_row), .write_count(write_count),
        .loaded(loaded), .overwrite_err(overwrite_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        p1_b <= int'(bank_select_line);
        p1_l <= int'(select_line);
        p1_o <= cur_ofs;
        p2_b <= p1_b;
        p2_l <= p1_l;
        p2_o <= p1_o;
    end

    assign rom_data = 32'(32'h100 + 8 * p2_b + p2_l + p2_o);
    assign ram_data = 32'(32'h200 + 8 * p2_b + p2_l + p2_o);

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic req(input int b, input int l, input int ofs, input logic en);
        @(negedge clk);
        read_en          = 1'b1;
        enable           = en;
        bank_select_line = 4'(b);
        select_line      = 3'(l);
        cur_ofs          = ofs;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            read_en = 1'b0;
            enable  = 1'b0;
        end
    endtask

    function automatic logic [31:0] lane(input logic [255:0] r, input int l);
        return r[l*32 +: 32];
    endfunction

    logic [255:0] exp_row;

    initial begin
        reset = 1'b1; enable = 1'b0; read_en = 1'b0; clear = 1'b0;
        bank_select_line = '0; select_line = '0; row_sel = '0;
        repeat (2) @(negedge clk);
        check("rst_cnt", write_count, 0);
        check("rst_loaded", loaded, 0);
        check("rst_err", overwrite_err, 0);
        check("rst_wrow", w_row, 0);
        check("rst_xrow", x_row, 0);
        reset = 1'b0;

        // Full pass, back-to-back, then the controller's terminal bank 8.
        for (int b = 0; b < 8; b++)
            for (int l = 0; l < 8; l++)
                req(b, l, 0, 1'b1);
        req(8, 0, 0, 1'b1);
        check("cnt_at_req63", write_count, 62);
        idle(1);
        check("cnt_req63_p1", write_count, 63);
        check("loaded_req63_p1", loaded, 0);
        idle(1);
        check("cnt_req63_p2", write_count, 64);
        check("loaded_req63_p2", loaded, 1);
        idle(3);
        check("cnt_after_term", write_count, 64);
        row_sel = 3'd3; #1;
        check("r3_l5_w", lane(w_row, 5), 32'h11D);
        check("r3_l5_x", lane(x_row, 5), 32'h21D);
        for (int l = 0; l < 8; l++) exp_row[l*32 +: 32] = 32'(32'h100 + 24 + l);
        check("r3_w_full", w_row, exp_row);
        row_sel = 3'd7; #1;
        check("r7_l7_w", lane(w_row, 7), 32'h13F);
        check("r7_l0_x", lane(x_row, 0), 32'h238);

        // Request after loaded is ignored.
        req(3, 5, 'h1000, 1'b1);
        idle(4);
        row_sel = 3'd3; #1;
        check("ign_r3_l5_w", lane(w_row, 5), 32'h11D);
        check("ign_cnt", write_count, 64);
        check("ign_loaded", loaded, 1);

        // Clear, then a second pass with a 5-cycle enable stall in the middle.
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clr_cnt", write_count, 0);
        check("clr_loaded", loaded, 0);
        for (int i = 0; i < 64; i++) begin
            if (i == 32) begin
                repeat (5) req(0, 0, 'h5000, 1'b0);
                check("stall_cnt", write_count, 32);
            end
            req(i / 8, i % 8, 'h20, 1'b1);
        end
        idle(4);
        check("p2_cnt", write_count, 64);
        check("p2_loaded", loaded, 1);
        check("p2_err", overwrite_err, 0);
        row_sel = 3'd0; #1;
        check("p2_r0_l0_w", lane(w_row, 0), 32'h120);
        row_sel = 3'd3; #1;
        check("p2_r3_l5_w", lane(w_row, 5), 32'h13D);
        check("p2_r3_l5_x", lane(x_row, 5), 32'h23D);

        // Clear coincident with the write of (0,0).
        req(0, 0, 'h40, 1'b1);
        idle(1);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clrw_cnt", write_count, 1);
        check("clrw_loaded", loaded, 0);
        check("clrw_err", overwrite_err, 0);
        row_sel = 3'd0; #1;
        check("clrw_r0_l0_w", lane(w_row, 0), 32'h140);
        check("clrw_r0_l0_x", lane(x_row, 0), 32'h240);

        // Same slot (2,4) requested twice in a fresh pass.
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        req(2, 4, 'h60, 1'b1);
        req(2, 4, 'h70, 1'b1);
        idle(4);
`ifdef BANK_LOADER_ERR_EN
        check("dup_cnt", write_count, 1);
        check("dup_err", overwrite_err, 1);
`else
        check("dup_cnt", write_count, 2);
        check("dup_err", overwrite_err, 0);
`endif
        row_sel = 3'd2; #1;
        check("dup_r2_l4_w", lane(w_row, 4), 32'h184);
        check("dup_r2_l4_x", lane(x_row, 4), 32'h284);

        // Reset with two tags in flight.
        req(5, 1, 'h80, 1'b1);
        req(5, 2, 'h80, 1'b1);
        @(negedge clk);
        read_en = 1'b0; enable = 1'b0;
        reset = 1'b1; row_sel = 3'd2; #1;
        check("arst_cnt", write_count, 0);
        check("arst_loaded", loaded, 0);
        check("arst_err", overwrite_err, 0);
        check("arst_r2_w", w_row, 0);
        #2 reset = 1'b0;
        idle(4);
        row_sel = 3'd5; #1;
        check("post_rst_cnt", write_count, 0);
        check("post_rst_r5_w", w_row, 0);
        check("post_rst_r5_x", x_row, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
